// File: rtl/norm_result_fifo_pkg.sv
// Shared types for the normalized-result serializer: lane indices and
// the aligned four-lane quotient set.
package norm_pkg;

    localparam int NUM_LANES = 4;
    localparam int DATAWIDTH = 16;
    localparam int LANE_W    = DATAWIDTH + 1;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

    // Lane A sits in the least-significant slot so a set indexes naturally by lane number.
    typedef struct packed {
        logic [LANE_W-1:0] d;
        logic [LANE_W-1:0] c;
        logic [LANE_W-1:0] b;
        logic [LANE_W-1:0] a;
    } vec_set_t;

endpackage

// File: rtl/norm_result_fifo_if.sv
// Bundles the per-lane divider inputs and the serialized ready/valid output
// stream of the normalized-result FIFO.
interface norm_result_fifo_if
    import norm_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int DEPTH     = 4
);

    logic                         i_valid_A;
    logic                         i_valid_B;
    logic                         i_valid_C;
    logic                         i_valid_D;
    logic [DATAWIDTH:0]           i_data_A;
    logic [DATAWIDTH:0]           i_data_B;
    logic [DATAWIDTH:0]           i_data_C;
    logic [DATAWIDTH:0]           i_data_D;
    logic                         i_ready;
    logic                         o_valid;
    logic [DATAWIDTH:0]           o_data;
    lane_idx_t                    o_lane;
    logic                         o_last;
    logic [$clog2(DEPTH+1)-1:0]   o_count;
    logic                         o_overflow;
    logic                         o_align_err;

    modport master (
        output i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        output i_data_A, i_data_B, i_data_C, i_data_D,
        output i_ready,
        input  o_valid, o_data, o_lane, o_last, o_count, o_overflow, o_align_err
    );

    modport slave (
        input  i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        input  i_data_A, i_data_B, i_data_C, i_data_D,
        input  i_ready,
        output o_valid, o_data, o_lane, o_last, o_count, o_overflow, o_align_err
    );

endinterface

// File: rtl/norm_result_fifo_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter so full and empty
// never alias when the pointers coincide.
module sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i & ~empty_o;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign doPush  = push_i & (~full_o | doPop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (doPush) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (doPop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/norm_result_fifo.sv
// Captures aligned four-lane quotient sets from the divider bank and replays
// them one lane per beat; losses and misaligned valids raise sticky flags.
module norm_result_fifo
    import norm_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    norm_result_fifo_if.slave  bus
);

    localparam int LW = DATAWIDTH + 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_state_e;

    lane_state_e                   lane_q, lane_d;
    logic                          overflow_q, overflow_d;
    logic                          alignErr_q, alignErr_d;
    logic [NUM_LANES-1:0]          laneValid;
    logic [NUM_LANES-1:0][LW-1:0]  inSet, headSet;
    logic                          allValid, partialValid;
    logic                          outValid, handshake, popSet, pushSet;
    logic                          fifoFull, fifoEmpty;
    logic [CW-1:0]                 fifoCount;

    assign laneValid    = {bus.i_valid_D, bus.i_valid_C, bus.i_valid_B, bus.i_valid_A};
    assign inSet        = {bus.i_data_D, bus.i_data_C, bus.i_data_B, bus.i_data_A};
    assign allValid     = &laneValid;
    assign partialValid = (|laneValid) & ~allValid;

    assign outValid  = ~fifoEmpty;
    assign handshake = outValid & bus.i_ready;
    assign popSet    = handshake & (lane_q == LANE3);
    assign pushSet   = allValid;

    sync_fifo #(
        .WIDTH (NUM_LANES * LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushSet),
        .pop_i   (popSet),
        .wdata_i (inSet),
        .rdata_o (headSet),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= LANE0;
            overflow_q <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
            alignErr_q <= alignErr_d;
        end
    end

    // Lane sequencing and flag accumulation; output data is forced to zero while empty.
    always_comb begin
        lane_d          = lane_q;
        overflow_d      = overflow_q | (allValid & fifoFull & ~popSet);
        alignErr_d      = alignErr_q | partialValid;
        bus.o_valid     = outValid;
        bus.o_data      = '0;
        bus.o_lane      = lane_idx_t'(lane_q);
        bus.o_last      = outValid & (lane_q == LANE3);
        bus.o_count     = fifoCount;
        bus.o_overflow  = overflow_q;
        bus.o_align_err = alignErr_q;

        if (outValid) begin
            bus.o_data = headSet[lane_q];
        end

        if (handshake) begin
            case (lane_q)
                LANE0:   lane_d = LANE1;
                LANE1:   lane_d = LANE2;
                LANE2:   lane_d = LANE3;
                default: lane_d = LANE0;
            endcase
        end
    end

endmodule
